// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem requests, one-entry skid buffer, redirect/kill.
// Optional build macro IFU_NOP_INSERT_EN: id_instruction reads addi x0,x0,0 whenever id_valid is low.
module ifu_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  id_stall,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_instruction,
    output logic [DATA_WIDTH-1:0] id_pc
);

`ifdef IFU_NOP_INSERT_EN
    localparam logic [DATA_WIDTH-1:0] IDLE_INSTR = DATA_WIDTH'(32'h0000_0013);
`else
    localparam logic [DATA_WIDTH-1:0] IDLE_INSTR = '0;
`endif

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state;
    logic                  kill;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] req_pc;
    logic [DATA_WIDTH-1:0] skid_instr;
    logic [DATA_WIDTH-1:0] skid_pc;
    logic                  out_free;
    logic [DATA_WIDTH-1:0] redirect_target;

    // Request is a decode of the state so it rises in the very first cycle after reset falls.
    assign imem_req_valid  = (state == REQ) && !rst;
    assign imem_addr       = pc;
    assign out_free        = !id_valid || !id_stall;
    assign redirect_target = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= REQ;
            kill           <= 1'b0;
            pc             <= RESET_PC;
            id_valid       <= 1'b0;
            id_pc          <= '0;
            id_instruction <= IDLE_INSTR;
        end else if (redirect_valid) begin
            // Flush: the output and skid contents belong to the abandoned path.
            pc             <= redirect_target;
            id_valid       <= 1'b0;
            id_instruction <= IDLE_INSTR;
            case (state)
                REQ: begin
                    if (imem_req_ready) begin
                        state <= WAIT;
                        kill  <= 1'b1;
                    end else begin
                        state <= REQ;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= REQ;
                        kill  <= 1'b0;
                    end else begin
                        kill  <= 1'b1;
                    end
                end
                default: state <= REQ;
            endcase
        end else begin
            if (id_valid && !id_stall) begin
                id_valid <= 1'b0;
`ifdef IFU_NOP_INSERT_EN
                id_instruction <= IDLE_INSTR;
`endif
            end
            case (state)
                REQ: begin
                    if (imem_req_ready) begin
                        req_pc <= pc;
                        pc     <= pc + DATA_WIDTH'(4);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else if (out_free) begin
                            id_instruction <= imem_rsp_data;
                            id_pc          <= req_pc;
                            id_valid       <= 1'b1;
                            state          <= REQ;
                        end else begin
                            skid_instr <= imem_rsp_data;
                            skid_pc    <= req_pc;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Skid is drained only when decode takes the word currently on the output.
                    if (!id_stall) begin
                        id_instruction <= skid_instr;
                        id_pc          <= skid_pc;
                        id_valid       <= 1'b1;
                        state          <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: fetch, stall/skid, redirects, PC wrap, mid-run reset.
// Build with or without IFU_NOP_INSERT_EN; the idle-slot expectation follows the macro.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;

    int vectors;
    int miscompares;

    // Memory responder state, advanced only by tick.
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    int          rsp_lat;

    logic [31:0] exp_idle;
    logic [31:0] exp_bubble;

    ifu_fetch #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_stall      (id_stall),
        .id_valid      (id_valid),
        .id_instruction(id_instruction),
        .id_pc         (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0000_0000: word = 32'h0050_0093;
            32'h0000_0004: word = 32'h00A0_0113;
            32'h0000_0008: word = 32'hDEAD_BEEF;
            default:       word = {a[23:0], 8'h13};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs settle and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (acc) begin
            pend  = 1'b1;
            paddr = a;
            cnt   = rsp_lat;
        end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word(paddr);
                pend           = 1'b0;
            end
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        pend           = 1'b0;
        paddr          = '0;
        cnt            = 0;
        rsp_lat        = 1;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_stall       = 1'b0;
`ifdef IFU_NOP_INSERT_EN
        exp_idle   = 32'h0000_0013;
        exp_bubble = 32'h0000_0013;
`else
        exp_idle   = 32'h0000_0000;
        exp_bubble = 32'h00A0_0113;
`endif

        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instruction, exp_idle);

        // Reset release, single-cycle memory.
        rst = 1'b0;
        #1;
        chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        tick();
        chk("c1_req_valid", 32'(imem_req_valid), 32'd0);
        chk("c1_id_valid", 32'(id_valid), 32'd0);
        tick();
        chk("c2_id_valid", 32'(id_valid), 32'd1);
        chk("c2_id_pc", id_pc, 32'h0);
        chk("c2_id_instr", id_instruction, 32'h0050_0093);
        chk("c2_addr", imem_addr, 32'h4);
        chk("c2_req_valid", 32'(imem_req_valid), 32'd1);

        // Stall for five cycles: second word parks in the skid buffer, no third request.
        id_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_id_valid", 32'(id_valid), 32'd1);
            chk("stall_id_pc", id_pc, 32'h0);
            chk("stall_id_instr", id_instruction, 32'h0050_0093);
            chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        end
        id_stall = 1'b0;
        tick();
        chk("unstall_id_valid", 32'(id_valid), 32'd1);
        chk("unstall_id_pc", id_pc, 32'h4);
        chk("unstall_id_instr", id_instruction, 32'h00A0_0113);
        chk("unstall_addr", imem_addr, 32'h8);

        // Redirect while waiting on a slow response that must be discarded.
        rsp_lat = 3;
        tick();
        chk("bubble_id_valid", 32'(id_valid), 32'd0);
        chk("bubble_id_instr", id_instruction, exp_bubble);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        chk("rdw_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rdw_addr", imem_addr, 32'h100);
        chk("rdw_id_instr", id_instruction, exp_idle);
        tick();
        chk("rdw_stale_rsp", 32'(imem_rsp_valid), 32'd1);
        tick();
        chk("rdw_drop_valid", 32'(id_valid), 32'd0);
        chk("rdw_drop_instr", id_instruction, exp_idle);
        chk("rdw_restart_req", 32'(imem_req_valid), 32'd1);
        chk("rdw_restart_addr", imem_addr, 32'h100);
        rsp_lat = 1;
        tick();
        tick();
        chk("rdw_tgt_valid", 32'(id_valid), 32'd1);
        chk("rdw_tgt_pc", id_pc, 32'h100);
        chk("rdw_tgt_instr", id_instruction, 32'h0001_0013);

        // Redirect coinciding with an accepted request while decode stalls.
        id_stall       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("rdr_id_valid", 32'(id_valid), 32'd0);
        chk("rdr_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rdr_addr", imem_addr, 32'h200);
        tick();
        chk("rdr_drop_valid", 32'(id_valid), 32'd0);
        chk("rdr_restart_req", 32'(imem_req_valid), 32'd1);
        chk("rdr_restart_addr", imem_addr, 32'h200);
        id_stall = 1'b0;
        tick();
        tick();
        chk("rdr_tgt_valid", 32'(id_valid), 32'd1);
        chk("rdr_tgt_pc", id_pc, 32'h200);
        chk("rdr_tgt_instr", id_instruction, 32'h0002_0013);

        // Redirect in REQ without ready, with low bits set, to the top word; then wrap.
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        chk("top_req_valid", 32'(imem_req_valid), 32'd1);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        chk("top_id_valid", 32'(id_valid), 32'd0);
        tick();
        tick();
        chk("top_id_valid2", 32'(id_valid), 32'd1);
        chk("top_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("top_id_instr", id_instruction, 32'hFFFF_FC13);
        chk("wrap_addr", imem_addr, 32'h0);

        // Redirect while HOLD: skid contents are flushed.
        id_stall = 1'b1;
        tick();
        tick();
        chk("hold_no_req", 32'(imem_req_valid), 32'd0);
        chk("hold_id_pc", id_pc, 32'hFFFF_FFFC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        id_stall       = 1'b0;
        chk("rdh_id_valid", 32'(id_valid), 32'd0);
        chk("rdh_id_instr", id_instruction, exp_idle);
        chk("rdh_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rdh_addr", imem_addr, 32'h40);
        tick();
        tick();
        chk("rdh_tgt_pc", id_pc, 32'h40);
        chk("rdh_tgt_instr", id_instruction, 32'h0000_4013);

        // Redirect in WAIT with the response in the same cycle.
        tick();
        chk("rws_rsp_now", 32'(imem_rsp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        tick();
        redirect_valid = 1'b0;
        chk("rws_id_valid", 32'(id_valid), 32'd0);
        chk("rws_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rws_addr", imem_addr, 32'h80);
        tick();
        tick();
        chk("rws_tgt_valid", 32'(id_valid), 32'd1);
        chk("rws_tgt_pc", id_pc, 32'h80);
        chk("rws_tgt_instr", id_instruction, 32'h0000_8013);

        // Mid-run reset with a response still in flight that lands in REQ.
        rsp_lat = 2;
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mrst_id_valid", 32'(id_valid), 32'd0);
        chk("mrst_id_pc", id_pc, 32'h0);
        chk("mrst_id_instr", id_instruction, exp_idle);
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        chk("stray_id_valid", 32'(id_valid), 32'd0);
        chk("stray_req_valid", 32'(imem_req_valid), 32'd1);
        chk("stray_addr", imem_addr, 32'h0);
        imem_req_ready = 1'b1;
        rsp_lat        = 1;
        tick();
        tick();
        chk("post_rst_valid", 32'(id_valid), 32'd1);
        chk("post_rst_pc", id_pc, 32'h0);
        chk("post_rst_instr", id_instruction, 32'h0050_0093);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
